// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-Stream to FIFO arbiter: FSM encoding,
// ID width helper and the field layout of the packed FIFO word.
package axis_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_e;

    // Requester id width, never narrower than one bit.
    function automatic int calcIdW(input int numReq);
        return (numReq <= 2) ? 1 : $clog2(numReq);
    endfunction

    // Packed word is {src_id, tlast, tdata} with tdata at bit 0.
    localparam int DATA_POS = 0;

    function automatic int tlastPos(input int dataWidth);
        return dataWidth;
    endfunction

    function automatic int idPos(input int dataWidth);
        return dataWidth + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from
// the requester after lastGrant_i, wrapping at NUM_REQ-1.
module rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = calcIdW(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    lastGrant_i,
    output logic [ID_W-1:0]    grant_o,
    output logic               anyReq_o
);

    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant_o  = '0;
        anyReq_o = 1'b0;
        idx      = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = ID_W'((int'(lastGrant_i) + off) % NUM_REQ);
            if (req_i[idx]) begin
                grant_o  = idx;
                anyReq_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_fifo_arbiter.sv
// Round-robin arbiter packing whole AXI-Stream packets into a shared FIFO.
// Define AXIS_ARB_TIMEOUT_EN to force-release a grant whose owner goes idle.
module axis_fifo_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_WIDTH     = 8,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int ID_W           = calcIdW(NUM_REQ),
    localparam int FW             = DATA_WIDTH + 1 + ID_W
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_REQ-1:0]            s_axis_tvalid,
    input  logic [NUM_REQ-1:0]            s_axis_tlast,
    output logic [NUM_REQ-1:0]            s_axis_tready,
    output logic                          fifo_wr_en,
    output logic [FW-1:0]                 fifo_data_in,
    input  logic                          fifo_full,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int TLAST_POS = tlastPos(DATA_WIDTH);
    localparam int ID_POS    = idPos(DATA_WIDTH);

    arbState_e       state_q, state_d;
    logic [ID_W-1:0] grantId_q, grantId_d;
    logic [ID_W-1:0] lastGrant_q, lastGrant_d;
    logic [ID_W-1:0] pickId;
    logic            anyReq;
    logic            timeoutHit;
    logic [DATA_WIDTH-1:0] tdataArr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : gSlice
        assign tdataArr[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) uRr (
        .req_i       (s_axis_tvalid),
        .lastGrant_i (lastGrant_q),
        .grant_o     (pickId),
        .anyReq_o    (anyReq)
    );

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q     <= IDLE;
            grantId_q   <= '0;
            lastGrant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            grantId_q   <= grantId_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Release only on a completed tlast beat or a forced timeout.
    always_comb begin
        state_d     = state_q;
        grantId_d   = grantId_q;
        lastGrant_d = lastGrant_q;
        unique case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d   = GRANT;
                    grantId_d = pickId;
                end
            end
            GRANT: begin
                if ((fifo_wr_en && s_axis_tlast[grantId_q]) || timeoutHit) begin
                    state_d     = IDLE;
                    lastGrant_d = grantId_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the handshake so nothing reaches the FIFO mid-reset.
    always_comb begin
        s_axis_tready = '0;
        fifo_wr_en    = 1'b0;
        fifo_data_in  = '0;
        if (arstn && state_q == GRANT) begin
            s_axis_tready[grantId_q] = ~fifo_full;
            fifo_wr_en = s_axis_tvalid[grantId_q] & ~fifo_full;
        end
        if (fifo_wr_en) begin
            fifo_data_in[DATA_POS +: DATA_WIDTH] = tdataArr[grantId_q];
            fifo_data_in[TLAST_POS]              = s_axis_tlast[grantId_q];
            fifo_data_in[ID_POS +: ID_W]         = grantId_q;
        end
    end

    assign grant_id = grantId_q;
    assign busy     = (state_q == GRANT);

`ifdef AXIS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idleCnt_q, idleCnt_d;
    logic             timeoutErr_q;

    // Counts consecutive idle-valid cycles; a full FIFO is not the owner's fault.
    always_comb begin
        idleCnt_d  = '0;
        timeoutHit = 1'b0;
        if (state_q == GRANT && !s_axis_tvalid[grantId_q] && !fifo_full) begin
            if (idleCnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeoutHit = 1'b1;
            end else begin
                idleCnt_d = idleCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            idleCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            idleCnt_q    <= idleCnt_d;
            timeoutErr_q <= timeoutHit;
        end
    end

    assign timeout_err = timeoutErr_q;
`else
    assign timeoutHit  = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Directed bench for axis_fifo_arbiter (4 requesters, 8-bit data, timeout 8).
module tb_axis_fifo_arbiter;

    logic        clk = 1'b0;
    logic        arstn;
    logic [31:0] tdata;
    logic [3:0]  tvalid;
    logic [3:0]  tlast;
    logic [3:0]  tready;
    logic        wrEn;
    logic [10:0] dataIn;
    logic        full;
    logic [1:0]  grantId;
    logic        busy;
    logic        timeoutErr;

    int testsRun    = 0;
    int testsFailed = 0;

    axis_fifo_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready),
        .fifo_wr_en    (wrEn),
        .fifo_data_in  (dataIn),
        .fifo_full     (full),
        .grant_id      (grantId),
        .busy          (busy),
        .timeout_err   (timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f);
        tvalid = v;
        tlast  = l;
        tdata  = d;
        full   = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mkWord(input logic [1:0] id, input logic last, input logic [7:0] d);
        return {id, last, d};
    endfunction

    initial begin
        arstn = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("rst_tready", tready, 4'b0000);
        checkOutput("rst_wr", wrEn, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_grant", grantId, 2'd0);
        checkOutput("rst_terr", timeoutErr, 1'b0);

        // Alternating single-beat packets from requesters 0 and 2.
        arstn = 1'b1;
        applyStimulus(4'b0101, 4'b0101, 32'hA3A2A1A0, 1'b0);
        checkOutput("alt_idle_wr", wrEn, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] expId;
            expId = (k % 2 == 1) ? 2'd2 : 2'd0;
            tick();
            checkOutput("alt_grant", grantId, expId);
            checkOutput("alt_tready", tready, 4'b0001 << expId);
            checkOutput("alt_wr", wrEn, 1'b1);
            checkOutput("alt_word", dataIn, mkWord(expId, 1'b1, 8'hA0 + 8'(expId)));
            tick();
            checkOutput("alt_gap_wr", wrEn, 1'b0);
            checkOutput("alt_gap_busy", busy, 1'b0);
        end
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);

        // Three-beat packet from requester 1 while requester 3 waits.
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        applyStimulus(4'b1010, 4'b1000, 32'hC300B000, 1'b0);
        tick();
        checkOutput("pkt_grant", grantId, 2'd1);
        checkOutput("pkt_tready", tready, 4'b0010);
        checkOutput("pkt_b0", dataIn, mkWord(2'd1, 1'b0, 8'hB0));
        tick();
        applyStimulus(4'b1010, 4'b1000, 32'hC300B100, 1'b0);
        checkOutput("pkt_b1_wr", wrEn, 1'b1);
        checkOutput("pkt_b1", dataIn, mkWord(2'd1, 1'b0, 8'hB1));
        tick();
        applyStimulus(4'b1010, 4'b1010, 32'hC300B200, 1'b0);
        checkOutput("pkt_b2", dataIn, mkWord(2'd1, 1'b1, 8'hB2));
        tick();
        applyStimulus(4'b1000, 4'b1000, 32'hC3000000, 1'b0);
        checkOutput("pkt_gap_busy", busy, 1'b0);
        checkOutput("pkt_gap_wr", wrEn, 1'b0);
        tick();
        checkOutput("pkt_next_grant", grantId, 2'd3);
        checkOutput("pkt_next_word", dataIn, mkWord(2'd3, 1'b1, 8'hC3));
        tick();
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);

        // Back-pressure for five cycles in the middle of a four-beat packet.
        applyStimulus(4'b0001, 4'b0000, 32'h000000D0, 1'b0);
        tick();
        checkOutput("full_b0", dataIn, mkWord(2'd0, 1'b0, 8'hD0));
        tick();
        applyStimulus(4'b0001, 4'b0000, 32'h000000D1, 1'b0);
        checkOutput("full_b1", dataIn, mkWord(2'd0, 1'b0, 8'hD1));
        tick();
        applyStimulus(4'b0001, 4'b0000, 32'h000000D2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("full_tready", tready, 4'b0000);
            checkOutput("full_wr", wrEn, 1'b0);
            checkOutput("full_busy", busy, 1'b1);
            tick();
        end
        applyStimulus(4'b0001, 4'b0000, 32'h000000D2, 1'b0);
        checkOutput("full_b2_wr", wrEn, 1'b1);
        checkOutput("full_b2", dataIn, mkWord(2'd0, 1'b0, 8'hD2));
        tick();
        applyStimulus(4'b0001, 4'b0001, 32'h000000D3, 1'b0);
        checkOutput("full_b3", dataIn, mkWord(2'd0, 1'b1, 8'hD3));
        tick();
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
        checkOutput("full_done_busy", busy, 1'b0);

        // Reset lands on beat 2 of requester 2's packet.
        applyStimulus(4'b0101, 4'b0000, 32'h00F000E0, 1'b0);
        tick();
        checkOutput("rmid_grant", grantId, 2'd2);
        checkOutput("rmid_b1", dataIn, mkWord(2'd2, 1'b0, 8'hF0));
        tick();
        arstn = 1'b0;
        applyStimulus(4'b0101, 4'b0000, 32'h00F100E0, 1'b0);
        checkOutput("rmid_tready_comb", tready, 4'b0000);
        checkOutput("rmid_wr_comb", wrEn, 1'b0);
        tick();
        checkOutput("rmid_tready", tready, 4'b0000);
        checkOutput("rmid_busy", busy, 1'b0);
        arstn = 1'b1;
        applyStimulus(4'b0101, 4'b0000, 32'h00F100E0, 1'b0);
        tick();
        checkOutput("rmid_regrant", grantId, 2'd0);
        checkOutput("rmid_regrant_tready", tready, 4'b0001);
        applyStimulus(4'b0101, 4'b0001, 32'h00F100E0, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);

        // Granted requester goes quiet after its first beat.
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        applyStimulus(4'b0101, 4'b0000, 32'h00420040, 1'b0);
        tick();
        checkOutput("to_b0", dataIn, mkWord(2'd0, 1'b0, 8'h40));
        tick();
        applyStimulus(4'b0100, 4'b0100, 32'h00420040, 1'b0);
`ifdef AXIS_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            checkOutput("to_hold_busy", busy, 1'b1);
            checkOutput("to_hold_terr", timeoutErr, 1'b0);
            tick();
        end
        checkOutput("to_pulse", timeoutErr, 1'b1);
        checkOutput("to_release_busy", busy, 1'b0);
        tick();
        checkOutput("to_pulse_end", timeoutErr, 1'b0);
        checkOutput("to_next_grant", grantId, 2'd2);
        checkOutput("to_next_word", dataIn, mkWord(2'd2, 1'b1, 8'h42));
        tick();
`else
        for (int i = 0; i < 20; i++) begin
            checkOutput("hold_busy", busy, 1'b1);
            checkOutput("hold_grant", grantId, 2'd0);
            checkOutput("hold_terr", timeoutErr, 1'b0);
            tick();
        end
        applyStimulus(4'b0101, 4'b0001, 32'h00420041, 1'b0);
        checkOutput("hold_end_word", dataIn, mkWord(2'd0, 1'b1, 8'h41));
        tick();
        checkOutput("hold_end_busy", busy, 1'b0);
`endif
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
